// File: rtl/clock_ctrl.sv
// Digital clock control: button sync/edge detect, mode/position FSM,
// count-pulse generation for time and alarm counters, alarm enable.
//
// Ports:
//   clk, rst                      clock, sync active-high reset
//   i_sw_mode/pos/inc/alarm       raw button levels (high = pressed)
//   i_tick_1hz                    1 Hz one-clk pulse
//   i_max_hit_sec/min             counter wrap levels
//   o_mode, o_position            current mode / edited field
//   o_sec/min/hour_clk            time counter count pulses
//   o_alarm_sec/min/hour_clk      alarm counter count pulses
//   o_alarm_en                    alarm enable level
module clock_ctrl #(
  parameter logic [1:0] MODE_CLOCK = 2'd0,
  parameter logic [1:0] MODE_SETUP = 2'd1,
  parameter logic [1:0] MODE_ALARM = 2'd2,
  parameter logic [1:0] POS_SEC    = 2'd0,
  parameter logic [1:0] POS_MIN    = 2'd1,
  parameter logic [1:0] POS_HOUR   = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  input  logic       i_sw_alarm,
  input  logic       i_tick_1hz,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk,
  output logic       o_alarm_en
);

  typedef enum logic [1:0] {
    M_CLOCK = MODE_CLOCK,
    M_SETUP = MODE_SETUP,
    M_ALARM = MODE_ALARM
  } mode_e;

  // button order: {alarm, inc, pos, mode}
  logic [3:0] sw;
  logic [3:0] s1_q, s2_q, s3_q;
  logic [3:0] arm_q, prs_q;
  logic [1:0] init_q;

  assign sw = {i_sw_alarm, i_sw_inc, i_sw_pos, i_sw_mode};

  // arm_q: a button only arms once it has been seen released after
  // reset, so a press held through reset never fires. init_q marks
  // when s2_q carries real post-reset samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      arm_q  <= '0;
      prs_q  <= '0;
      init_q <= '0;
    end else begin
      s1_q   <= sw;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      init_q <= {init_q[0], 1'b1};
      arm_q  <= arm_q | ({4{init_q[1]}} & ~s2_q);
      prs_q  <= s2_q & ~s3_q & arm_q;
    end
  end

  logic p_mode, p_pos, p_inc, p_alm;

  // mode press wins over position and increment
  assign p_mode = prs_q[0];
  assign p_pos  = prs_q[1] & ~p_mode;
  assign p_inc  = prs_q[2] & ~p_mode;
  assign p_alm  = prs_q[3];

  mode_e      mode_q, mode_d;
  logic [1:0] pos_q, pos_d;
  logic       alm_en_q, alm_en_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= M_CLOCK;
      pos_q    <= POS_SEC;
      alm_en_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      pos_q    <= pos_d;
      alm_en_q <= alm_en_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      M_CLOCK: if (p_mode) mode_d = M_SETUP;
      M_SETUP: if (p_mode) mode_d = M_ALARM;
      M_ALARM: if (p_mode) mode_d = M_CLOCK;
      default: mode_d = M_CLOCK;
    endcase
  end

  always_comb begin
    pos_d = pos_q;
    if (p_mode) begin
      pos_d = POS_SEC;
    end else if (p_pos && mode_q != M_CLOCK) begin
      case (pos_q)
        POS_SEC: pos_d = POS_MIN;
        POS_MIN: pos_d = POS_HOUR;
        default: pos_d = POS_SEC;
      endcase
    end
  end

  assign alm_en_d = alm_en_q ^ p_alm;

  logic hit_sec_q, hit_min_q;
  logic rise_sec, rise_min;
  logic run, setup, alset;
  logic at_sec, at_min, at_hour;
  logic [5:0] req, pls_d, pls_q;

  // edge regs track even in SETUP so no stale edge fires on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_sec_q <= 1'b0;
      hit_min_q <= 1'b0;
      pls_q     <= '0;
    end else begin
      hit_sec_q <= i_max_hit_sec;
      hit_min_q <= i_max_hit_min;
      pls_q     <= pls_d;
    end
  end

  assign rise_sec = i_max_hit_sec & ~hit_sec_q;
  assign rise_min = i_max_hit_min & ~hit_min_q;
  assign run      = (mode_q == M_CLOCK) || (mode_q == M_ALARM);
  assign setup    = (mode_q == M_SETUP);
  assign alset    = (mode_q == M_ALARM);
  assign at_sec   = (pos_q == POS_SEC);
  assign at_min   = (pos_q == POS_MIN);
  assign at_hour  = (pos_q == POS_HOUR);

  // order: {a_hour, a_min, a_sec, hour, min, sec}
  assign req[0] = (run & i_tick_1hz) | (setup & p_inc & at_sec);
  assign req[1] = (run & rise_sec)   | (setup & p_inc & at_min);
  assign req[2] = (run & rise_min)   | (setup & p_inc & at_hour);
  assign req[3] = alset & p_inc & at_sec;
  assign req[4] = alset & p_inc & at_min;
  assign req[5] = alset & p_inc & at_hour;

  // guarantee a low cycle after every pulse
  assign pls_d = req & ~pls_q;

  assign o_mode           = mode_q;
  assign o_position       = pos_q;
  assign o_alarm_en       = alm_en_q;
  assign o_sec_clk        = pls_q[0];
  assign o_min_clk        = pls_q[1];
  assign o_hour_clk       = pls_q[2];
  assign o_alarm_sec_clk  = pls_q[3];
  assign o_alarm_min_clk  = pls_q[4];
  assign o_alarm_hour_clk = pls_q[5];

endmodule
